// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Frame accumulator behind the 8x8 signed multiplier. Signed products arrive
//   over a valid/ready handshake, are sign-extended into a one-entry input
//   register and summed into a wide accumulator. A frame closes after LEN
//   samples or on an accepted sample flagged in_last. The sum, the sample count
//   and a sticky overflow flag are then held on a valid/ready output until taken.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high
//   in_valid   in   1       product valid
//   in_ready   out  1       block can accept a product (state only)
//   in_data    in   PROD_W  signed product
//   in_last    in   1       accepted sample is the last of its frame
//   out_valid  out  1       frame result valid
//   out_ready  in   1       downstream accepts result
//   out_data   out  ACC_W   signed frame sum
//   out_count  out  8       samples in frame (1..LEN)
//   out_ovf    out  1       signed overflow seen during the frame
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 48,
  parameter int LEN    = 8,
  parameter int SAT    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [7:0]               out_count,
  output logic                     out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]             LEN_C   = 8'(LEN);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state;
  state_t                    state_next;
  logic [7:0]                count;
  logic                      accept;
  logic                      out_fire;
  logic                      close_frame;

  logic signed [ACC_W-1:0]   data_p1;
  logic                      vld_p1;
  logic signed [ACC_W-1:0]   acc_p2;
  logic                      ovf_p2;
  logic signed [ACC_W-1:0]   sum_p2;
  logic                      add_ovf_p2;

  // Adds two ACC_W operands; returns {overflow, result}. Overflow is the
  // classic sign rule: equal operand signs, different result sign. With SAT
  // set the result clamps toward the sign of the operands.
  function automatic logic [ACC_W:0] add_sat(input logic signed [ACC_W-1:0] a,
                                              input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic                    o;
    s = a + b;
    o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    if (o && (SAT != 0)) begin
      s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    return {o, s};
  endfunction

  assign accept      = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign close_frame = in_last || ((count + 8'd1) == LEN_C);
  assign {add_ovf_p2, sum_p2} = add_sat(acc_p2, data_p1);

  always_comb begin
    state_next = state;
    in_ready   = (state == ACCUM);
    out_valid  = (state == DONE);
    case (state)
      ACCUM:   if (accept && close_frame) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
      count <= 8'd0;
    end else begin
      state <= state_next;
      if (out_fire) begin
        count <= 8'd0;
      end else if (accept) begin
        count <= count + 8'd1;
      end
    end
  end

  // ---- stage 1: capture accepted sample, sign-extended to ACC_W ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
      end
    end
  end

  // ---- stage 2: accumulate; cleared when the result is taken ----
  // vld_p1 is never set in DONE, so clear and add cannot collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (out_fire) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= sum_p2;
      if (add_ovf_p2) ovf_p2 <= 1'b1;
    end
  end

  assign out_data  = acc_p2;
  assign out_count = count;
  assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [15:0] in_data;
  logic in_last;
  logic out_ready;

  logic in_ready0, out_valid0, out_ovf0;
  logic signed [47:0] out_data0;
  logic [7:0] out_count0;
  logic in_ready1, out_valid1, out_ovf1;
  logic signed [16:0] out_data1;
  logic [7:0] out_count1;
  logic in_ready2, out_valid2, out_ovf2;
  logic signed [16:0] out_data2;
  logic [7:0] out_count2;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;
  bit rnd = 1'b0;

  typedef struct {
    longint d0, d1, d2;
    int     cnt;
    bit     o0, o1, o2;
  } exp_t;
  exp_t sb[$];

  longint m_acc0, m_acc1, m_acc2;
  bit     m_o0, m_o1, m_o2;
  int     m_cnt;

  always #5 clk = ~clk;

  product_accumulator u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0),
    .out_ovf(out_ovf0));

  product_accumulator #(.ACC_W(17), .SAT(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1),
    .out_ovf(out_ovf1));

  product_accumulator #(.ACC_W(17), .SAT(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
    .out_ovf(out_ovf2));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact-arithmetic reference: detect out-of-range sum, then wrap or clamp.
  function automatic longint step(input longint a, input longint x, input int w,
                                  input bit sat, inout bit o);
    longint one, mx, mn, s;
    one = 1;
    mx  = (one << (w - 1)) - 1;
    mn  = -mx - 1;
    s   = a + x;
    if (s > mx) begin
      o = 1'b1;
      s = sat ? mx : s - 2 * (mx + 1);
    end else if (s < mn) begin
      o = 1'b1;
      s = sat ? mn : s + 2 * (mx + 1);
    end
    return s;
  endfunction

  task automatic model_clear();
    m_acc0 = 0; m_acc1 = 0; m_acc2 = 0;
    m_o0 = 0; m_o1 = 0; m_o2 = 0;
    m_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom);
  endtask

  task automatic send(input logic signed [15:0] d, input bit last);
    bit got;
    exp_t e;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      got = in_ready0;
      tick();
      if (got) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) begin
      check("send_timeout", 0, 1);
    end else begin
      m_acc0 = step(m_acc0, longint'(d), 48, 1'b0, m_o0);
      m_acc1 = step(m_acc1, longint'(d), 17, 1'b0, m_o1);
      m_acc2 = step(m_acc2, longint'(d), 17, 1'b1, m_o2);
      m_cnt++;
      if (last || m_cnt == 8) begin
        e.d0 = m_acc0; e.d1 = m_acc1; e.d2 = m_acc2;
        e.cnt = m_cnt; e.o0 = m_o0; e.o1 = m_o1; e.o2 = m_o2;
        sb.push_back(e);
        pushed++;
        model_clear();
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
    if (sb.size() != 0) check("drain_timeout", longint'(sb.size()), 0);
    tick();
  endtask

  task automatic wait_out_valid(input string tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid0) break;
    end
    check(tag, out_valid0, 1);
  endtask

  // Scoreboard: compare every result at the cycle it is handed over.
  always @(negedge clk) begin
    if (!reset && out_valid0 && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        check("sum48", out_data0, e.d0);
        check("count", out_count0, e.cnt);
        check("ovf48", out_ovf0, e.o0);
        check("sum17_wrap", out_data1, e.d1);
        check("ovf17_wrap", out_ovf1, e.o1);
        check("sum17_sat", out_data2, e.d2);
        check("ovf17_sat", out_ovf2, e.o2);
        check("lockstep", {out_valid1, out_valid2, in_ready0, in_ready1, in_ready2,
                           out_count1 == out_count0, out_count2 == out_count0},
              7'b1100011);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    #1;
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_count", out_count0, 0);
    check("rst_out_ovf", out_ovf0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();

    // Products 1..8, out_ready high early; frame closes on count.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    @(negedge clk);
    check("t1_flush_valid", out_valid0, 0);
    check("t1_flush_ready", in_ready0, 0);
    @(negedge clk);
    check("t1_done_valid", out_valid0, 1);
    check("t1_sum_const", out_data0, 36);
    tick();
    drain();

    // Three -16256 with in_last on the third.
    for (int i = 0; i < 3; i++) send(-16'sd16256, i == 2);
    wait_out_valid("t2_done");
    check("t2_sum_const", out_data0, -48768);
    check("t2_count_const", out_count0, 3);
    tick();
    drain();

    // Back-pressure in DONE; an offered sample must not be taken.
    out_ready = 1'b0;
    send(16'sd5, 1'b0);
    send(16'sd6, 1'b1);
    wait_out_valid("t3_done");
    in_valid = 1'b1;
    in_data  = 16'sd100;
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready0, 0);
      check("t3_hold_data", out_data0, 11);
      check("t3_hold_count", out_count0, 2);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_in_ready_back", in_ready0, 1);
    tick();
    send(16'sd7, 1'b1);
    drain();

    // Overflow on the narrow instances: wrap and saturate.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'sd32767, i == 2);
    wait_out_valid("t4_done");
    check("t4_wrap_const", out_data1, -32771);
    check("t4_wrap_ovf", out_ovf1, 1);
    check("t4_sat_const", out_data2, 65535);
    check("t4_sat_ovf", out_ovf2, 1);
    check("t4_wide_const", out_data0, 98301);
    tick();
    drain();

    // Asynchronous reset between edges, mid-frame.
    for (int i = 0; i < 4; i++) send(16'sd3, 1'b0);
    check("t5_count_before", out_count0, 4);
    #3;
    reset = 1'b1;
    #1;
    check("t5_out_data", out_data0, 0);
    check("t5_out_count", out_count0, 0);
    check("t5_out_valid", out_valid0, 0);
    check("t5_in_ready", in_ready0, 1);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send(16'sd1, 1'b0);
    wait_out_valid("t5_done");
    check("t5_sum_const", out_data0, 8);
    tick();
    drain();

    // Random throttled frames against the reference model.
    rnd = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      bit lst;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        lst = (i == len - 1) && ((len < 8) || ($urandom_range(0, 1) == 1));
        send(16'($urandom), lst);
      end
    end
    rnd = 1'b0;
    drain();
    check("sb_empty", longint'(sb.size()), 0);
    check("frames_match", popped, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
